// File: rtl/wr_control.sv
// wr_control: skewed per-column write enables and row addresses for de-skewing systolic array outputs
module wr_control #(
  parameter int width_height = 16,
  localparam int data_width = width_height*8,
  localparam int count_width = $clog2(2*width_height)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [7:0]              base_addr,
  output logic [width_height-1:0] wr_en,
  output logic [data_width-1:0]   wr_addr,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [count_width-1:0] last = count_width'(2*width_height-2);
  state_t                  state_q, state_d;
  logic [count_width-1:0]  count_q, count_d;
  logic [7:0]              base_q, base_d;
  logic                    active_q;
  logic                    start, wr_d, done_d, busy_d;
  logic [width_height-1:0] wr_en_d;
  logic [data_width-1:0]   wr_addr_d;
  assign start = active & ~active_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = WRITE;
        count_d = '0;
        base_d  = base_addr;
        wr_d    = 1'b1;
      end
      WRITE: if (count_q == last) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
        wr_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    wr_en_d = '0;
    wr_addr_d = '0;
    // column i sees row k-i of the skewed output while that row is inside the array
    for (int i = 0; i < width_height; i++) begin
      wr_en_d[i] = wr_d && 32'(count_d) >= 32'(i) && 32'(count_d) <= 32'(i + width_height - 1);
      wr_addr_d[8*i +: 8] = wr_en_d[i] ? base_d + 8'(32'(count_d) - 32'(i)) : 8'h00;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      base_q   <= '0;
      active_q <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      base_q   <= base_d;
      active_q <= active;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end
endmodule

// File: tb/tb_wr_control.sv
// tb_wr_control: directed and randomized bursts on N=16 and N=4 instances against a cycle-indexed model
module tb_wr_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic act16 = 1'b0, act4 = 1'b0;
  logic [7:0] base16 = '0, base4 = '0;
  logic [15:0] en16;
  logic [127:0] a16;
  logic [3:0] en4;
  logic [31:0] a4;
  logic busy16, done16, busy4, done4;
  logic sel = 1'b0;
  int npass = 0, ntotal = 0;
  wr_control #(.width_height(16)) dut16 (
    .clk(clk), .reset(reset), .active(act16), .base_addr(base16),
    .wr_en(en16), .wr_addr(a16), .busy(busy16), .done(done16)
  );
  wr_control #(.width_height(4)) dut4 (
    .clk(clk), .reset(reset), .active(act4), .base_addr(base4),
    .wr_en(en4), .wr_addr(a4), .busy(busy4), .done(done4)
  );
  always #5 clk = ~clk;
  logic [127:0] obs_en, obs_addr;
  logic obs_busy, obs_done;
  assign obs_en   = sel ? 128'(en4) : 128'(en16);
  assign obs_addr = sel ? 128'(a4) : a16;
  assign obs_busy = sel ? busy4 : busy16;
  assign obs_done = sel ? done4 : done16;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  // k cycles after the start edge, column i writes row k-i if that row exists
  function automatic logic [127:0] exp_en(input int n, input int k);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = k >= i && k - i < n;
    return r;
  endfunction
  function automatic logic [127:0] exp_addr(input int n, input int k, input logic [7:0] b);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) if (k >= i && k - i < n) r[8*i +: 8] = 8'(int'(b) + k - i);
    return r;
  endfunction
  task automatic set_act(input logic v);
    if (sel) act4 = v; else act16 = v;
  endtask
  task automatic set_base(input logic [7:0] v);
    if (sel) base4 = v; else base16 = v;
  endtask
  task automatic run_burst(input int n, input logic [7:0] b, input bit wiggle);
    set_act(1'b0);
    tick();
    set_base(b);
    set_act(1'b1);
    tick();
    for (int k = 0; k <= 2*n-2; k++) begin
      chk($sformatf("n%0d b%0h k%0d wr_en", n, b, k), obs_en, exp_en(n, k));
      chk($sformatf("n%0d b%0h k%0d wr_addr", n, b, k), obs_addr, exp_addr(n, k, b));
      chk($sformatf("n%0d k%0d busy", n, k), 128'(obs_busy), 128'(1));
      chk($sformatf("n%0d k%0d done", n, k), 128'(obs_done), 128'(0));
      set_base(8'($urandom));
      set_act((wiggle && k < 2*n-3) ? 1'($urandom) : 1'b1);
      tick();
    end
    chk($sformatf("n%0d end done", n), 128'(obs_done), 128'(1));
    chk($sformatf("n%0d end busy", n), 128'(obs_busy), 128'(1));
    chk($sformatf("n%0d end wr_en", n), obs_en, 128'(0));
    chk($sformatf("n%0d end wr_addr", n), obs_addr, 128'(0));
    tick();
    chk($sformatf("n%0d idle done", n), 128'(obs_done), 128'(0));
    chk($sformatf("n%0d idle busy", n), 128'(obs_busy), 128'(0));
    chk($sformatf("n%0d idle wr_en", n), obs_en, 128'(0));
  endtask
  initial begin
    repeat (3) tick();
    chk("reset wr_en", obs_en, 128'(0));
    chk("reset wr_addr", obs_addr, 128'(0));
    chk("reset busy", 128'(obs_busy), 128'(0));
    chk("reset done", 128'(obs_done), 128'(0));
    reset = 1'b0;
    tick();
    run_burst(16, 8'h40, 1'b0);
    repeat (40 - 2*16 - 1) begin
      chk("held active no restart busy", 128'(obs_busy), 128'(0));
      chk("held active no restart done", 128'(obs_done), 128'(0));
      tick();
    end
    run_burst(16, 8'h40, 1'b0);
    run_burst(16, 8'hF8, 1'b0);
    repeat (3) run_burst(16, 8'($urandom), 1'b1);
    set_act(1'b0);
    tick();
    set_base(8'h22);
    set_act(1'b1);
    tick();
    repeat (9) tick();
    chk("pre-abort wr_en k9", obs_en, exp_en(16, 9));
    #2 reset = 1'b1;
    #1;
    chk("abort wr_en", obs_en, 128'(0));
    chk("abort wr_addr", obs_addr, 128'(0));
    chk("abort busy", 128'(obs_busy), 128'(0));
    chk("abort done", 128'(obs_done), 128'(0));
    set_act(1'b0);
    tick();
    reset = 1'b0;
    repeat (20) begin
      chk("post-abort done", 128'(obs_done), 128'(0));
      chk("post-abort busy", 128'(obs_busy), 128'(0));
      tick();
    end
    run_burst(16, 8'h22, 1'b0);
    sel = 1'b1;
    #1;
    chk("n4 idle wr_en", obs_en, 128'(0));
    run_burst(4, 8'h10, 1'b0);
    repeat (4) run_burst(4, 8'($urandom), 1'b1);
    run_burst(4, 8'hFE, 1'b0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
